prog_delay_line: RTL and testbench

PROG_DELAY_LINE -- requirements
Module: prog_delay_line

---
 rtl/dl_stage.sv | 27 ++
 rtl/prog_delay_line.sv | 105 ++++++++++
 tb/tb_prog_delay_line.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dl_stage.sv
`default_nettype none
// ============================================================================
// Module   : dl_stage
// Purpose  : One pipeline register with an enable and a synchronous clear that loads a supplied value.
// Revision : 1.0
// ============================================================================
module dl_stage #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] clr_val,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= clr_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : prog_delay_line
// Purpose  : Delay line with a run-time latency of 0..MAX_DEPTH enabled cycles, valid tracking, flush and a fill status.
// Revision : 1.0
// ============================================================================
module prog_delay_line #(
    parameter int                 WIDTH      = 4,
    parameter int                 MAX_DEPTH  = 16,
    parameter logic [WIDTH-1:0]   RESET_DATA = '0,
    localparam int                DELAY_W    = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               flush,
    input  logic [DELAY_W-1:0] delay,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    output logic               primed,
    output logic               delay_err
);

    localparam logic [DELAY_W-1:0] c_MAX_DEPTH = DELAY_W'(MAX_DEPTH);

    logic [WIDTH:0]       w_stage_q [1:MAX_DEPTH];
    logic [DELAY_W-1:0]   r_delay_q;
    logic [DELAY_W-1:0]   r_fill;
    logic                 w_change;
    logic                 w_hard_clr;
    logic                 w_clr;
    logic                 w_over;
    logic [DELAY_W-1:0]   w_tap;

    assign w_change   = (delay != r_delay_q);
    assign w_hard_clr = rst | flush;
    assign w_clr      = w_hard_clr | w_change;
    assign w_over     = (delay > c_MAX_DEPTH);
    assign w_tap      = w_over ? c_MAX_DEPTH : delay;

    // A delay change only drops valid bits; the data bits reload their own value.
    generate
        for (genvar k = 1; k <= MAX_DEPTH; k++) begin : g_stage
            logic [WIDTH:0] w_d;
            logic [WIDTH:0] w_clr_val;

            if (k == 1) begin : g_first
                assign w_d = {in_valid, in};
            end else begin : g_rest
                assign w_d = w_stage_q[k-1];
            end

            assign w_clr_val = w_hard_clr ? {1'b0, RESET_DATA}
                                          : {1'b0, w_stage_q[k][WIDTH-1:0]};

            dl_stage #(
                .W (WIDTH + 1)
            ) u_stage (
                .clk     (clk),
                .clr     (w_clr),
                .clr_val (w_clr_val),
                .en      (en),
                .d       (w_d),
                .q       (w_stage_q[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        r_delay_q <= delay;
        if (rst) begin
            r_fill    <= '0;
            delay_err <= 1'b0;
        end else begin
            delay_err <= w_over;
            if (flush || w_change) begin
                r_fill <= '0;
            end else if (en && (r_fill != c_MAX_DEPTH)) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign primed = (delay == '0) || (r_fill >= delay);

    always_comb begin
        out       = RESET_DATA;
        out_valid = 1'b0;
        if (delay == '0) begin
            out       = in;
            out_valid = in_valid;
        end else begin
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                if (w_tap == DELAY_W'(k)) begin
                    out       = w_stage_q[k][WIDTH-1:0];
                    out_valid = w_stage_q[k][WIDTH] & ~w_over;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_delay_line
// Purpose  : Directed self-checking bench for prog_delay_line (WIDTH=4, MAX_DEPTH=16).
// Revision : 1.0
// ============================================================================
module tb_prog_delay_line;

    localparam int WIDTH     = 4;
    localparam int MAX_DEPTH = 16;
    localparam int DELAY_W   = $clog2(MAX_DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               flush;
    logic [DELAY_W-1:0] delay;
    logic               in_valid;
    logic [WIDTH-1:0]   in;
    logic [WIDTH-1:0]   out;
    logic               out_valid;
    logic               primed;
    logic               delay_err;

    int n_tests = 0;
    int n_fail  = 0;

    prog_delay_line #(
        .WIDTH      (WIDTH),
        .MAX_DEPTH  (MAX_DEPTH),
        .RESET_DATA (4'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .delay     (delay),
        .in_valid  (in_valid),
        .in        (in),
        .out       (out),
        .out_valid (out_valid),
        .primed    (primed),
        .delay_err (delay_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; delay = 5'd3; in_valid = 1'b0; in = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out",       32'(out),       32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_primed",    32'(primed),    32'h0);
        check("rst_delay_err", 32'(delay_err), 32'h0);

        // fixed latency of 3
        for (int c = 0; c < 6; c++) begin
            en = 1'b1; in_valid = 1'b1; in = 4'(c + 1);
            #1;
            check("lat3_valid",  32'(out_valid), (c >= 3) ? 32'h1 : 32'h0);
            check("lat3_primed", 32'(primed),    (c >= 3) ? 32'h1 : 32'h0);
            check("lat3_out",    32'(out),       (c >= 3) ? 32'(c - 2) : 32'h0);
            tick();
        end

        // stall at delay 2
        delay = 5'd2; en = 1'b0; in_valid = 1'b0;
        tick();
        en = 1'b1; in_valid = 1'b1; in = 4'hA; #1;
        check("stall_v0", 32'(out_valid), 32'h0);
        tick();
        en = 1'b0; in = 4'hB; #1;
        check("stall_v1", 32'(out_valid), 32'h0);
        check("stall_p1", 32'(primed),    32'h0);
        tick();
        en = 1'b1; in = 4'hB; #1;
        check("stall_v2", 32'(out_valid), 32'h0);
        tick();
        en = 1'b0; in_valid = 1'b0; #1;
        check("stall_out", 32'(out),       32'hA);
        check("stall_v3",  32'(out_valid), 32'h1);
        check("stall_p3",  32'(primed),    32'h1);
        tick();
        check("stall_hold_out", 32'(out),       32'hA);
        check("stall_hold_v",   32'(out_valid), 32'h1);

        // delay change 4 -> 2 mid-stream
        for (int c = 0; c < 13; c++) begin
            en = 1'b1; in_valid = 1'b1; in = 4'(c + 1);
            delay = (c < 8) ? 5'd4 : 5'd2;
            #1;
            if (c >= 5 && c <= 7) begin
                check("chg_d4_out", 32'(out),       32'(c - 3));
                check("chg_d4_v",   32'(out_valid), 32'h1);
            end
            if (c == 9 || c == 10) check("chg_gap_v", 32'(out_valid), 32'h0);
            if (c >= 11) begin
                check("chg_d2_out", 32'(out),       32'(c - 1));
                check("chg_d2_v",   32'(out_valid), 32'h1);
            end
            tick();
        end

        // flush beats en in the same cycle
        flush = 1'b1; en = 1'b1; in_valid = 1'b1; in = 4'h5;
        tick();
        flush = 1'b0; in_valid = 1'b0; in = 4'h0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("flush_v",   32'(out_valid), 32'h0);
            check("flush_out", 32'(out),       32'h0);
            if (c == 0) check("flush_primed", 32'(primed), 32'h0);
            tick();
        end

        // delay 0 is combinational pass-through
        delay = 5'd0; en = 1'b0; in_valid = 1'b1; in = 4'h7; #1;
        check("d0_out",    32'(out),       32'h7);
        check("d0_v",      32'(out_valid), 32'h1);
        check("d0_primed", 32'(primed),    32'h1);
        tick();
        in = 4'h3; #1;
        check("d0_out2", 32'(out), 32'h3);

        // delay MAX_DEPTH
        delay = 5'd16; en = 1'b0; in_valid = 1'b0;
        tick();
        for (int c = 0; c <= 16; c++) begin
            en = 1'b1; in_valid = (c == 0); in = (c == 0) ? 4'h9 : 4'h0;
            #1;
            if (c == 15) begin
                check("d16_v15", 32'(out_valid), 32'h0);
                check("d16_p15", 32'(primed),    32'h0);
            end
            if (c == 16) begin
                check("d16_out", 32'(out),       32'h9);
                check("d16_v",   32'(out_valid), 32'h1);
                check("d16_p",   32'(primed),    32'h1);
            end
            tick();
        end

        // illegal delay
        delay = 5'd17; en = 1'b1; in_valid = 1'b1; in = 4'h1; #1;
        check("d17_v_now",   32'(out_valid), 32'h0);
        check("d17_err_now", 32'(delay_err), 32'h0);
        tick();
        check("d17_err",    32'(delay_err), 32'h1);
        check("d17_v",      32'(out_valid), 32'h0);
        check("d17_primed", 32'(primed),    32'h0);
        delay = 5'd3;
        tick();
        check("d3_err_clr", 32'(delay_err), 32'h0);

        // reset with three samples in flight
        for (int c = 0; c < 3; c++) begin
            en = 1'b1; in_valid = 1'b1; in = 4'(c + 1);
            tick();
        end
        #1;
        check("pre_rst_v",   32'(out_valid), 32'h1);
        check("pre_rst_out", 32'(out),       32'h1);
        rst = 1'b1; in = 4'h4;
        tick();
        rst = 1'b0; in_valid = 1'b0; in = 4'h0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("rst_ms_v",   32'(out_valid), 32'h0);
            check("rst_ms_out", 32'(out),       32'h0);
            if (c == 0) check("rst_ms_primed", 32'(primed), 32'h0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
